// File: rtl/mem_arbiter.sv
// mem_arbiter: registered one-access-per-cycle arbiter sharing mem between DMA, execute and fetch
// Optional starvation guard for EXE/FCH is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dma_req,
  input  logic                  dma_lock,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  input  logic                  exe_req,
  input  logic                  exe_we,
  input  logic [ADDR_WIDTH-1:0] exe_addr,
  input  logic [DATA_WIDTH-1:0] exe_wdata,
  output logic                  exe_gnt,
  output logic                  exe_rvalid,
  input  logic                  fch_req,
  input  logic [ADDR_WIDTH-1:0] fch_addr,
  output logic                  fch_gnt,
  output logic                  fch_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);
  typedef enum logic [1:0] {OWN_NONE, OWN_DMA, OWN_EXE, OWN_FCH} own_t;
  own_t gnt_own, rd_own, win, rr_pick, starve_pick;
  logic rr_fch, dma_last, e_dma, e_exe, e_fch, s_exe, s_fch;
  if (STARVE_LIMIT < 1) begin : g_limit_check
    $error("mem_arbiter: STARVE_LIMIT must be at least 1");
  end
  assign dma_gnt    = gnt_own == OWN_DMA;
  assign exe_gnt    = gnt_own == OWN_EXE;
  assign fch_gnt    = gnt_own == OWN_FCH;
  assign dma_rvalid = rd_own == OWN_DMA;
  assign exe_rvalid = rd_own == OWN_EXE;
  assign fch_rvalid = rd_own == OWN_FCH;
  assign rdata      = rd_own == OWN_NONE ? '0 : mem_dout;
  // A locked DMA stays eligible while granted so a burst gets a grant every cycle
  assign e_dma = dma_req && (gnt_own != OWN_DMA || dma_lock);
  assign e_exe = exe_req && gnt_own != OWN_EXE;
  assign e_fch = fch_req && gnt_own != OWN_FCH;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  logic [CW-1:0] cnt_exe, cnt_fch;
  assign s_exe = e_exe && cnt_exe == LIMIT;
  assign s_fch = e_fch && cnt_fch == LIMIT;
  always_ff @(posedge clk)
    if (reset) begin
      cnt_exe <= '0;
      cnt_fch <= '0;
    end else begin
      cnt_exe <= win == OWN_EXE ? '0 : e_exe && cnt_exe != LIMIT ? cnt_exe + 1'b1 : cnt_exe;
      cnt_fch <= win == OWN_FCH ? '0 : e_fch && cnt_fch != LIMIT ? cnt_fch + 1'b1 : cnt_fch;
    end
`else
  assign s_exe = 1'b0;
  assign s_fch = 1'b0;
`endif
  always_comb begin
    rr_pick     = e_exe && !(e_fch && rr_fch) ? OWN_EXE : e_fch ? OWN_FCH : OWN_NONE;
    starve_pick = s_exe && !(s_fch && rr_fch) ? OWN_EXE : s_fch ? OWN_FCH : OWN_NONE;
    win = starve_pick != OWN_NONE ? starve_pick :
          e_dma                   ? OWN_DMA     :
          dma_lock && dma_last    ? OWN_NONE    : rr_pick;
  end
  // rd_own tags the access mem is completing, so rvalid never depends on the current grant
  always_ff @(posedge clk)
    if (reset) begin
      gnt_own  <= OWN_NONE;
      rd_own   <= OWN_NONE;
      rr_fch   <= 1'b0;
      dma_last <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      gnt_own <= win;
      rd_own  <= mem_we ? OWN_NONE : gnt_own;
      mem_we  <= (win == OWN_DMA && dma_we) || (win == OWN_EXE && exe_we);
      if (win != OWN_NONE) begin
        mem_addr <= win == OWN_DMA ? dma_addr : win == OWN_EXE ? exe_addr : fch_addr;
        dma_last <= win == OWN_DMA;
      end
      if (win == OWN_DMA) mem_din <= dma_wdata;
      else if (win == OWN_EXE) mem_din <= exe_wdata;
      if (win == OWN_EXE || win == OWN_FCH) rr_fch <= win == OWN_EXE;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_mem_arbiter;
  localparam int AW = 16, DW = 8, SL = 8;
  logic clk = 1'b0, reset;
  logic dma_req, dma_lock, dma_we, dma_gnt, dma_rvalid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic exe_req, exe_we, exe_gnt, exe_rvalid;
  logic [AW-1:0] exe_addr;
  logic [DW-1:0] exe_wdata;
  logic fch_req, fch_gnt, fch_rvalid;
  logic [AW-1:0] fch_addr;
  logic [DW-1:0] rdata, mem_din, mem_dout;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem [0:65535];
  bit wr [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .exe_req(exe_req), .exe_we(exe_we), .exe_addr(exe_addr), .exe_wdata(exe_wdata),
    .exe_gnt(exe_gnt), .exe_rvalid(exe_rvalid),
    .fch_req(fch_req), .fch_addr(fch_addr), .fch_gnt(fch_gnt), .fch_rvalid(fch_rvalid),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  function automatic logic [DW-1:0] pat(logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3c;
  endfunction

  function automatic logic [2:0] onehot(int w);
    return w == 0 ? 3'b100 : w == 1 ? 3'b010 : w == 2 ? 3'b001 : 3'b000;
  endfunction

  // Synchronous single-port memory: dout reflects the address presented on the previous cycle
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
      wr[mem_addr] <= 1'b1;
    end
    mem_dout <= wr[mem_addr] ? mem[mem_addr] : pat(mem_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    exe_req = 0; exe_we = 0; exe_addr = '0; exe_wdata = '0;
    fch_req = 0; fch_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    fch_req = 1; fch_addr = 16'h0007;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({dma_gnt, dma_rvalid, exe_gnt, exe_rvalid, fch_gnt, fch_rvalid, mem_we} !== 7'b0 ||
          mem_addr !== '0 || mem_din !== '0 || rdata !== '0) begin
        fails++;
        $display("FAIL reset_outs: gnt/rv/we=%b addr=%h din=%h rdata=%h, want all 0",
                 {dma_gnt, dma_rvalid, exe_gnt, exe_rvalid, fch_gnt, fch_rvalid, mem_we}, mem_addr, mem_din, rdata);
      end
    end
    reset = 0;
    step();
    checks++;
    if (fch_gnt !== 1'b1 || mem_addr !== 16'h0007 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_gnt: fch_gnt=%b addr=%h we=%b, want 1/0007/0", fch_gnt, mem_addr, mem_we);
    end
    fch_req = 0;
    step();
    checks++;
    if (fch_rvalid !== 1'b1 || rdata !== ref_mem[16'h0007] || fch_gnt !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_rvalid: rvalid=%b rdata=%h gnt=%b, want 1/%h/0", fch_rvalid, rdata, fch_gnt, ref_mem[16'h0007]);
    end
  endtask

  task automatic test_dma_write_fch_read();
    dma_req = 1; dma_we = 1; dma_addr = 16'h0003; dma_wdata = 8'hA5;
    step();
    checks++;
    if (dma_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0003 || mem_din !== 8'hA5) begin
      fails++;
      $display("FAIL dma_write: gnt=%b we=%b addr=%h din=%h, want 1/1/0003/a5", dma_gnt, mem_we, mem_addr, mem_din);
    end
    ref_mem[16'h0003] = 8'hA5;
    dma_req = 0; dma_we = 0;
    fch_req = 1; fch_addr = 16'h0003;
    step();
    checks++;
    if (fch_gnt !== 1'b1 || mem_we !== 1'b0 || dma_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL fch_read_gnt: gnt=%b we=%b dma_rvalid=%b, want 1/0/0", fch_gnt, mem_we, dma_rvalid);
    end
    fch_req = 0;
    step();
    checks++;
    if (fch_rvalid !== 1'b1 || rdata !== 8'hA5 || dma_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL fch_read_data: rvalid=%b rdata=%h dma_rvalid=%b, want 1/a5/0", fch_rvalid, rdata, dma_rvalid);
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] prev;
    reset = 1;
    exe_req = 1; exe_we = 0; exe_addr = 16'h0010;
    fch_req = 1; fch_addr = 16'h0011;
    step();
    reset = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (exe_gnt !== (k % 2 == 0) || fch_gnt !== (k % 2 == 1)) begin
        fails++;
        $display("FAIL rr_gnt[%0d]: exe=%b fch=%b, want %b/%b", k, exe_gnt, fch_gnt, k % 2 == 0, k % 2 == 1);
      end
      if (k > 0) begin
        prev = (k % 2 == 1) ? 16'h0010 : 16'h0011;
        checks++;
        if (exe_rvalid !== (k % 2 == 1) || fch_rvalid !== (k % 2 == 0) || rdata !== ref_mem[prev]) begin
          fails++;
          $display("FAIL rr_rvalid[%0d]: exe=%b fch=%b rdata=%h, want %b/%b/%h",
                   k, exe_rvalid, fch_rvalid, rdata, k % 2 == 1, k % 2 == 0, ref_mem[prev]);
        end
      end
    end
    exe_req = 0; fch_req = 0;
    step();
    checks++;
    if (fch_rvalid !== 1'b1 || exe_rvalid !== 1'b0 || rdata !== ref_mem[16'h0011]) begin
      fails++;
      $display("FAIL rr_last_rvalid: fch=%b exe=%b rdata=%h, want 1/0/%h", fch_rvalid, exe_rvalid, rdata, ref_mem[16'h0011]);
    end
    step();
  endtask

  task automatic test_lock();
    exe_req = 1; exe_we = 0; exe_addr = 16'h0020;
    dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = 16'h0030; dma_wdata = 8'h60;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (dma_gnt !== 1'b1 || exe_gnt !== 1'b0 || mem_addr !== 16'(16'h0030 + i) || mem_din !== 8'(8'h60 + i)) begin
        fails++;
        $display("FAIL lock_burst[%0d]: dma=%b exe=%b addr=%h din=%h, want 1/0/%h/%h",
                 i, dma_gnt, exe_gnt, mem_addr, mem_din, 16'(16'h0030 + i), 8'(8'h60 + i));
      end
      ref_mem[16'(16'h0030 + i)] = 8'(8'h60 + i);
      dma_addr = 16'(16'h0031 + i);
      dma_wdata = 8'(8'h61 + i);
    end
    dma_req = 0;
    step();
    checks++;
    if (exe_gnt !== 1'b0 || dma_gnt !== 1'b0) begin
      fails++;
      $display("FAIL lock_idle_hold: exe=%b dma=%b, want 0/0", exe_gnt, dma_gnt);
    end
    dma_lock = 0; dma_we = 0;
    step();
    checks++;
    if (exe_gnt !== 1'b1 || mem_addr !== 16'h0020 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL lock_release: exe=%b addr=%h we=%b, want 1/0020/0", exe_gnt, mem_addr, mem_we);
    end
    exe_req = 0;
    step();
    checks++;
    if (exe_rvalid !== 1'b1 || rdata !== ref_mem[16'h0020] || dma_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL lock_exe_data: rvalid=%b rdata=%h dma_rvalid=%b, want 1/%h/0", exe_rvalid, rdata, dma_rvalid, ref_mem[16'h0020]);
    end
  endtask

  task automatic test_reset_mid();
    exe_req = 1; exe_we = 0; exe_addr = 16'h0031;
    step();
    checks++;
    if (exe_gnt !== 1'b1) begin
      fails++;
      $display("FAIL mid_gnt: exe_gnt=%b, want 1", exe_gnt);
    end
    exe_req = 0;
    reset = 1;
    step();
    checks++;
    if (exe_rvalid !== 1'b0 || rdata !== '0 || exe_gnt !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: rvalid=%b rdata=%h gnt=%b, want 0/00/0", exe_rvalid, rdata, exe_gnt);
    end
    reset = 0;
    step();
    checks++;
    if (exe_rvalid !== 1'b0 || rdata !== '0) begin
      fails++;
      $display("FAIL mid_after: rvalid=%b rdata=%h, want 0/00", exe_rvalid, rdata);
    end
  endtask

  task automatic test_starvation();
    int first = 0, dma_cnt = 0;
    reset = 1;
    dma_req = 1; dma_lock = 1; dma_we = 1; dma_addr = 16'h0050; dma_wdata = 8'h77;
    fch_req = 1; fch_addr = 16'h0051;
    step();
    reset = 0;
    ref_mem[16'h0050] = 8'h77;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int c = 1; c <= 20 && first == 0; c++) begin
      step();
      if (fch_gnt === 1'b1) first = c;
    end
    checks++;
    if (first != SL + 1) begin
      fails++;
      $display("FAIL starve_promote: fch_gnt first at cycle %0d, want %0d", first, SL + 1);
    end
    fch_req = 0;
    step();
    checks++;
    if (dma_gnt !== 1'b1 || fch_rvalid !== 1'b1 || rdata !== ref_mem[16'h0051]) begin
      fails++;
      $display("FAIL starve_resume: dma=%b fch_rv=%b rdata=%h, want 1/1/%h", dma_gnt, fch_rvalid, rdata, ref_mem[16'h0051]);
    end
    dma_req = 0; dma_lock = 0; dma_we = 0;
`else
    for (int c = 1; c <= 16; c++) begin
      step();
      if (fch_gnt === 1'b1 && first == 0) first = c;
      if (dma_gnt === 1'b1) dma_cnt++;
    end
    checks++;
    if (first != 0 || dma_cnt != 16) begin
      fails++;
      $display("FAIL lock_starves_fch: first fch_gnt=%0d dma grants=%0d, want 0/16", first, dma_cnt);
    end
    dma_req = 0; dma_lock = 0; dma_we = 0;
    step();
    checks++;
    if (fch_gnt !== 1'b1 || mem_addr !== 16'h0051) begin
      fails++;
      $display("FAIL lock_drop_fch: gnt=%b addr=%h, want 1/0051", fch_gnt, mem_addr);
    end
    fch_req = 0;
    step();
    checks++;
    if (fch_rvalid !== 1'b1 || rdata !== ref_mem[16'h0051]) begin
      fails++;
      $display("FAIL lock_drop_data: rvalid=%b rdata=%h, want 1/%h", fch_rvalid, rdata, ref_mem[16'h0051]);
    end
`endif
    clear_inputs();
    step();
    step();
  endtask

  // Transaction-level model: who should win each cycle, and which read returns next
  task automatic test_random();
    logic req_v [3], we_v [3];
    logic [AW-1:0] ad_v [3];
    logic [DW-1:0] wd_v [3];
    logic lk = 0, fch_pref = 0, last_dma = 0, relock;
    logic e0, e1, e2;
    logic [DW-1:0] rd_next = '0, exp_rd;
    int m_gnt = -1, win, rd_owner = -1, exp_rv;
    for (int i = 0; i < 3; i++) begin
      req_v[i] = 0; we_v[i] = 0; ad_v[i] = '0; wd_v[i] = '0;
    end
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      relock = (m_gnt == 0) || !req_v[0];
      for (int i = 0; i < 3; i++)
        if (!req_v[i] || m_gnt == i) begin
          req_v[i] = 1'($urandom_range(0, 1));
          ad_v[i] = 16'($urandom_range(0, 31));
          we_v[i] = (i == 2) ? 1'b0 : 1'($urandom_range(0, 1));
          wd_v[i] = 8'($urandom);
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
      lk = 0;
`else
      if (relock) lk = ($urandom_range(0, 3) == 0);
`endif
      dma_req = req_v[0]; dma_lock = lk; dma_we = we_v[0]; dma_addr = ad_v[0]; dma_wdata = wd_v[0];
      exe_req = req_v[1]; exe_we = we_v[1]; exe_addr = ad_v[1]; exe_wdata = wd_v[1];
      fch_req = req_v[2]; fch_addr = ad_v[2];
      e0 = req_v[0] && (m_gnt != 0 || lk);
      e1 = req_v[1] && m_gnt != 1;
      e2 = req_v[2] && m_gnt != 2;
      if (e0) win = 0;
      else if (lk && last_dma) win = -1;
      else if (e1 && e2) win = fch_pref ? 2 : 1;
      else if (e1) win = 1;
      else if (e2) win = 2;
      else win = -1;
      step();
      exp_rv = rd_owner;
      exp_rd = rd_next;
      m_gnt = win;
      rd_owner = -1;
      if (win >= 0) begin
        if (we_v[win]) ref_mem[ad_v[win]] = wd_v[win];
        else begin
          rd_owner = win;
          rd_next = ref_mem[ad_v[win]];
        end
        if (win == 0) last_dma = 1;
        else begin
          last_dma = 0;
          fch_pref = (win == 1);
        end
      end
      checks++;
      if ({dma_gnt, exe_gnt, fch_gnt} !== onehot(win)) begin
        fails++;
        $display("FAIL rand_gnt[%0d]: dma/exe/fch=%b, want %b", cyc, {dma_gnt, exe_gnt, fch_gnt}, onehot(win));
      end
      checks++;
      if ({dma_rvalid, exe_rvalid, fch_rvalid} !== onehot(exp_rv) || rdata !== (exp_rv >= 0 ? exp_rd : 8'h00)) begin
        fails++;
        $display("FAIL rand_rvalid[%0d]: rv=%b rdata=%h, want %b/%h", cyc,
                 {dma_rvalid, exe_rvalid, fch_rvalid}, rdata, onehot(exp_rv), exp_rv >= 0 ? exp_rd : 8'h00);
      end
      checks++;
      if (mem_we !== (win >= 0 && we_v[win]) ||
          (win >= 0 && mem_addr !== ad_v[win]) || (win >= 0 && we_v[win] && mem_din !== wd_v[win])) begin
        fails++;
        $display("FAIL rand_mem[%0d]: we=%b addr=%h din=%h, winner %0d", cyc, mem_we, mem_addr, mem_din, win);
      end
    end
    clear_inputs();
    step();
    step();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ref_mem[a] = pat(16'(a));
    clear_inputs();
    reset = 1;
    test_reset();
    test_dma_write_fch_read();
    test_round_robin();
    test_lock();
    test_reset_mid();
    test_starvation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter that shares the one `mem` instance between three requesters: DMA loader, execute-stage load/store path and instruction fetcher.
- Sits between the fetcher/decoder datapath and `mem`; replaces the ad-hoc address/data muxing with a registered, fair, one-access-per-cycle scheduler.
- Returns read data to the requester that issued the access, tagged with a valid pulse.

Parameters:
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 8, memory data width
STARVE_LIMIT, 8, wait cycles before starvation promotion (used only with the optional feature)

Ports:
clk  in  1  system clock (phi-domain clock feeding mem)
reset  in  1  synchronous, active-high reset
dma_req  in  1  DMA access request
dma_lock  in  1  DMA burst lock; keeps ownership while high
dma_we  in  1  DMA write enable
dma_addr  in  ADDR_WIDTH  DMA address
dma_wdata  in  DATA_WIDTH  DMA write data
dma_gnt  out  1  DMA grant pulse
dma_rvalid  out  1  DMA read data valid
exe_req, exe_we, exe_addr, exe_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  execute-stage request bundle
exe_gnt, exe_rvalid  out  1/1  execute grant / read valid
fch_req, fch_addr  in  1/ADDR_WIDTH  fetcher request (read only)
fch_gnt, fch_rvalid  out  1/1  fetch grant / read valid
rdata  out  DATA_WIDTH  read data shared by all requesters; qualify with *_rvalid
mem_we  out  1  to mem.we
mem_addr  out  ADDR_WIDTH  to mem.addr
mem_din  out  DATA_WIDTH  to mem.din
mem_dout  in  DATA_WIDTH  from mem.dout; valid the cycle after address presented

Behaviour:
- Reset: all gnt, rvalid, mem_we low; mem_addr, mem_din, rdata = 0; round-robin pointer = EXE-preferred; lock released; in-flight reads discarded (no rvalid after reset).
- Arbitration evaluated every clk edge; at most one grant per cycle.
- Eligible request: req high AND that requester's gnt currently low. Exception: DMA with dma_lock high is eligible while dma_gnt high, allowing back-to-back DMA grants every cycle.
- Priority: DMA > {EXE, FCH}. EXE vs FCH: round robin; pointer flips to the other requester after each EXE or FCH grant. Single eligible requester wins regardless of pointer.
- Lock: while dma_lock high and DMA granted last, EXE/FCH not granted even if DMA idle for a cycle. Lock releases on dma_lock low.
- Timing: request seen in cycle N -> gnt pulse high and mem_addr/mem_we/mem_din registered in cycle N+1 -> mem samples at end of N+1 -> for reads, rvalid of that requester high with rdata = mem_dout in cycle N+2. Writes produce no rvalid.
- gnt is a one-cycle pulse; requester holds addr/we/wdata stable until gnt seen, then may drop or change them.
- FCH requests are always reads (mem_we = 0).
- Idle cycle: mem_we = 0; mem_addr holds last value.
- Pipelined: a new grant may issue in the same cycle as the previous access's rvalid; rvalid routing is tracked by a registered owner tag, never by current gnt.
- Reset asserted mid-access: granted access is dropped; no rvalid issued; next grant no earlier than 1 cycle after reset deasserts.

Optional Feature:
- Macro MEM_ARB_STARVE_GUARD_EN.
- With it: per-requester wait counters for EXE and FCH count cycles while eligible but not granted. When a counter reaches STARVE_LIMIT, that requester outranks DMA (including lock) for exactly one grant, then its counter clears. Counters saturate and clear on grant or reset. If EXE and FCH both reach the limit, the round-robin pointer breaks the tie.
- Without it: strict priority and lock as above; DMA can starve EXE/FCH indefinitely.

Test Plan:
- Reset with fch_req=1: all outputs 0 during reset. First fch_gnt one cycle after reset low, fch_rvalid the cycle after that.
- DMA write addr 0x0003 data 0xA5, then FCH read 0x0003: mem_we=1/addr 0x0003/din 0xA5 on dma_gnt cycle. fch_rvalid later with rdata=0xA5, dma_rvalid never high.
- EXE and FCH both requesting continuously after reset: grants alternate EXE, FCH, EXE, FCH. Each rvalid lands 1 cycle after its gnt with the matching data.
- DMA with dma_lock=1 for 4 addresses, EXE requesting throughout: dma_gnt high 4 consecutive cycles, no exe_gnt until lock drops, then exe_gnt next cycle.
- Reset pulsed the cycle after an exe_gnt read: no exe_rvalid; rdata=0.
- With MEM_ARB_STARVE_GUARD_EN and STARVE_LIMIT=8: dma_lock held, FCH requesting. fch_gnt issued after 8 waiting cycles despite the lock, then DMA resumes.
